// File: rtl/build_info_regs.sv
// Build-version and qualified USR_ACCESS capture exposed through a single-cycle register read port.
// USR_ACCESS data is captured only after DATAVALID has been synchronised and the data held stable.
module build_info_regs #(
  parameter int unsigned VER_W      = 64,
  parameter int unsigned STABLE_CYC = 4,
  parameter logic [31:0] ERR_DATA   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VER_W-1:0] version_i,
  input  logic [31:0]      usr_data_i,
  input  logic             usr_datavalid_i,
  input  logic             rearm_i,
  input  logic             rd_req_i,
  input  logic [3:0]       rd_addr_i,
  output logic             rd_ack_o,
  output logic [31:0]      rd_data_o,
  output logic             rd_err_o,
  output logic             usr_valid_o,
  output logic [31:0]      usr_word_o
);

  localparam int unsigned NV    = VER_W / 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STABLE   = 2'd1,
    CAPTURED = 2'd2
  } state_e;

  state_e             state_q;
  logic               dv_meta_q;
  logic               dv_s_q;
  logic [31:0]        shadow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        usr_word_q;
  logic               usr_valid_q;
  logic [15:0]        cap_cnt_q;
  logic               rd_ack_q;
  logic [31:0]        rd_data_q;
  logic               rd_err_q;
  logic [31:0]        rd_word_c;
  logic               rd_bad_c;
  logic [31:0]        status_c;

  // Two-flop synchroniser for the asynchronous DATAVALID strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_meta_q <= 1'b0;
      dv_s_q    <= 1'b0;
    end else begin
      dv_meta_q <= usr_datavalid_i;
      dv_s_q    <= dv_meta_q;
    end
  end

  // Capture FSM: data must stay valid and unchanged for STABLE_CYC cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= 32'd0;
      cnt_q       <= '0;
      usr_word_q  <= 32'd0;
      usr_valid_q <= 1'b0;
      cap_cnt_q   <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dv_s_q) begin
            state_q  <= STABLE;
            shadow_q <= usr_data_i;
            cnt_q    <= '0;
          end
        end
        STABLE: begin
          if (!dv_s_q) begin
            state_q <= IDLE;
          end else if (usr_data_i != shadow_q) begin
            shadow_q <= usr_data_i;
            cnt_q    <= '0;
          end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
            state_q     <= CAPTURED;
            usr_word_q  <= shadow_q;
            usr_valid_q <= 1'b1;
            if (cap_cnt_q != 16'hFFFF) begin
              cap_cnt_q <= cap_cnt_q + 16'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CAPTURED: begin
          if (rearm_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign status_c = {cap_cnt_q, 8'(NV), 5'd0, state_q, usr_valid_q};

  // Read decode uses pre-update register values, so a read racing a capture sees the old state
  always_comb begin
    rd_word_c = ERR_DATA;
    rd_bad_c  = 1'b1;
    for (int unsigned i = 0; i < NV; i++) begin
      if (32'(rd_addr_i) == i) begin
        rd_word_c = version_i[32*i +: 32];
        rd_bad_c  = 1'b0;
      end
    end
    if (32'(rd_addr_i) == NV) begin
      rd_word_c = usr_word_q;
      rd_bad_c  = 1'b0;
    end else if (32'(rd_addr_i) == NV + 1) begin
      rd_word_c = status_c;
      rd_bad_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= 32'd0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_ack_q <= rd_req_i;
      rd_err_q <= rd_req_i & rd_bad_c;
      if (rd_req_i) begin
        rd_data_q <= rd_word_c;
      end
    end
  end

  assign rd_ack_o    = rd_ack_q;
  assign rd_data_o   = rd_data_q;
  assign rd_err_o    = rd_err_q;
  assign usr_valid_o = usr_valid_q;
  assign usr_word_o  = usr_word_q;

endmodule

// File: tb/tb_build_info_regs.sv
// Scoreboard bench for build_info_regs: default instance plus a VER_W=256 instance for address-map bounds.
module tb_build_info_regs;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  version;
  logic [31:0]  usr_data;
  logic         dv;
  logic         rearm;
  logic         rd_req;
  logic [3:0]   rd_addr;
  logic         ack;
  logic [31:0]  data;
  logic         err;
  logic         valid;
  logic [31:0]  word;

  logic [255:0] version2;
  logic         rd_req2;
  logic [3:0]   rd_addr2;
  logic         ack2;
  logic [31:0]  data2;
  logic         err2;
  logic         valid2;
  logic [31:0]  word2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1;
  exp_t m2;
  int checks = 0;
  int errors = 0;

  build_info_regs #(.VER_W(64), .STABLE_CYC(4), .ERR_DATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .version_i(version), .usr_data_i(usr_data),
    .usr_datavalid_i(dv), .rearm_i(rearm), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_ack_o(ack), .rd_data_o(data), .rd_err_o(err),
    .usr_valid_o(valid), .usr_word_o(word)
  );

  build_info_regs #(.VER_W(256), .STABLE_CYC(4), .ERR_DATA(32'h0000_0000)) dut2 (
    .clk(clk), .rst(rst), .version_i(version2), .usr_data_i(32'd0),
    .usr_datavalid_i(1'b0), .rearm_i(1'b0), .rd_req_i(rd_req2), .rd_addr_i(rd_addr2),
    .rd_ack_o(ack2), .rd_data_o(data2), .rd_err_o(err2),
    .usr_valid_o(valid2), .usr_word_o(word2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] d, input logic e);
    rd_req  = 1'b1;
    rd_addr = a;
    q1.push_back('{d, e});
    step();
  endtask

  task automatic rd2(input logic [3:0] a, input logic [31:0] d, input logic e);
    rd_req2  = 1'b1;
    rd_addr2 = a;
    q2.push_back('{d, e});
    step();
  endtask

  task automatic rd_end();
    rd_req  = 1'b0;
    rd_req2 = 1'b0;
    repeat (3) step();
  endtask

  // Monitors: pop expected responses whenever an ack appears
  always @(negedge clk) begin
    if (ack) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected_ack actual=1 required=0");
      end else begin
        m1 = q1.pop_front();
        chk("rd_data", data, m1.d);
        chk("rd_err", 32'(err), 32'(m1.e));
      end
    end else begin
      chk("rd_err_no_ack", 32'(err), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (ack2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd2_unexpected_ack actual=1 required=0");
      end else begin
        m2 = q2.pop_front();
        chk("rd2_data", data2, m2.d);
        chk("rd2_err", 32'(err2), 32'(m2.e));
      end
    end
  end

  initial begin
    version  = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 8; i++) version2[32*i +: 32] = 32'hA000_0000 + 32'(i);
    usr_data = 32'd0;
    dv       = 1'b0;
    rearm    = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = 4'd0;
    rd_req2  = 1'b0;
    rd_addr2 = 4'd0;
    repeat (3) step();
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_data", data, 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_word", word, 32'd0);
    rst = 1'b0;
    step();

    // Back-to-back reads after reset
    rd(4'd0, 32'h89AB_CDEF, 1'b0);
    rd(4'd1, 32'h0123_4567, 1'b0);
    rd(4'd2, 32'h0000_0000, 1'b0);
    rd(4'd3, 32'h0000_0200, 1'b0);
    rd_end();

    // First capture: valid rises 7 cycles after DATAVALID; a read in the capture cycle sees the old word
    usr_data = 32'hCAFE_F00D;
    dv = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("cap1_valid_c%0d", i), 32'(valid), (i == 7) ? 32'd1 : 32'd0);
      if (i == 6) begin
        rd_req = 1'b1;
        rd_addr = 4'd2;
        q1.push_back('{32'h0000_0000, 1'b0});
      end else begin
        rd_req = 1'b0;
      end
    end
    chk("cap1_word", word, 32'hCAFE_F00D);
    rd(4'd3, 32'h0001_0205, 1'b0);
    rd_end();

    // Rearm with DATAVALID held: old word readable until recapture
    usr_data = 32'hAAAA_5555;
    repeat (2) step();
    chk("captured_holds_word", word, 32'hCAFE_F00D);
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("rearm_valid_c%0d", i), 32'(valid), 32'd1);
      chk($sformatf("rearm_word_c%0d", i), word, (i == 5) ? 32'hAAAA_5555 : 32'hCAFE_F00D);
      if (i == 1) begin
        rd_req = 1'b1;
        rd_addr = 4'd2;
        q1.push_back('{32'hCAFE_F00D, 1'b0});
      end else begin
        rd_req = 1'b0;
      end
    end
    rd(4'd3, 32'h0002_0205, 1'b0);
    rd_end();

    // Data change during STABLE restarts the counter and delays the capture by two cycles
    dv = 1'b0;
    repeat (3) step();
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    repeat (2) step();
    rd(4'd3, 32'h0002_0201, 1'b0);
    rd_end();
    usr_data = 32'hDEAD_BEEF;
    dv = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 4) usr_data = 32'h1111_2222;
      chk($sformatf("restart_valid_c%0d", i), 32'(valid), 32'd1);
      chk($sformatf("restart_word_c%0d", i), word, (i == 9) ? 32'h1111_2222 : 32'hAAAA_5555);
      if (i == 5) begin
        rd_req = 1'b1;
        rd_addr = 4'd3;
        q1.push_back('{32'h0002_0203, 1'b0});
      end else begin
        rd_req = 1'b0;
      end
    end
    rd(4'd3, 32'h0003_0205, 1'b0);
    rd(4'd2, 32'h1111_2222, 1'b0);
    rd_end();

    // Out-of-range addresses on both widths
    rd(4'hF, 32'h0000_0000, 1'b1);
    rd(4'd4, 32'h0000_0000, 1'b1);
    rd(4'd0, 32'h89AB_CDEF, 1'b0);
    rd_end();
    rd2(4'd9, 32'h0000_0800, 1'b0);
    rd2(4'd10, 32'h0000_0000, 1'b1);
    rd2(4'd7, 32'hA000_0007, 1'b0);
    rd2(4'd8, 32'h0000_0000, 1'b0);
    rd2(4'd0, 32'hA000_0000, 1'b0);
    rd_end();

    // Reset in STABLE with a read request in the reset cycle: no ack, full recapture afterwards
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    repeat (2) step();
    rd_req = 1'b1;
    rd_addr = 4'd0;
    rst = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_word", word, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("recap_valid_c%0d", i), 32'(valid), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("recap_word", word, 32'h1111_2222);
    rd(4'd3, 32'h0001_0205, 1'b0);
    rd_end();

    repeat (3) step();
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
